// File: rtl/mc_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_unit
// Purpose  : Multi-cycle control FSM for the MIPS-subset datapath. Sequences
//            fetch, decode, execute, memory and write-back. Moore datapath
//            controls, plus Mealy handshake outputs in the memory states.
//            Also tracks a sticky illegal-opcode flag and counts retired
//            instructions.
// Ports    : clk_i, rst_i (async, active-low)
//            instr_op_i       opcode from IR, sampled in DECODE only
//            mem_ready_i      memory completes current access this cycle
//            pc_write_o, pc_write_cond_o, pc_source_o, i_or_d_o,
//            mem_read_o, mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o,
//            reg_write_o, alu_src_a_o, alu_src_b_o, alu_op_o
//                             datapath mux selects and enables
//            retire_o         pulse in the final state of a legal instruction
//            illegal_o        sticky illegal-opcode flag
//            retired_cnt_o    wrapping retired-instruction count
//            state_o          current state encoding (debug)
// Revision : 1.0  initial release
// ============================================================================
module mc_ctrl_unit #(
    parameter int OP_W      = 6,
    parameter int ALUOP_W   = 3,
    parameter int CNT_W     = 16,
    parameter int USE_READY = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [OP_W-1:0]    instr_op_i,
    input  logic               mem_ready_i,
    output logic               pc_write_o,
    output logic               pc_write_cond_o,
    output logic [1:0]         pc_source_o,
    output logic               i_or_d_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic               ir_write_o,
    output logic               reg_dst_o,
    output logic               mem_to_reg_o,
    output logic               reg_write_o,
    output logic               alu_src_a_o,
    output logic [1:0]         alu_src_b_o,
    output logic [ALUOP_W-1:0] alu_op_o,
    output logic               retire_o,
    output logic               illegal_o,
    output logic [CNT_W-1:0]   retired_cnt_o,
    output logic [3:0]         state_o
);

    localparam logic [3:0] c_st_idle     = 4'd0;
    localparam logic [3:0] c_st_fetch    = 4'd1;
    localparam logic [3:0] c_st_decode   = 4'd2;
    localparam logic [3:0] c_st_mem_addr = 4'd3;
    localparam logic [3:0] c_st_mem_rd   = 4'd4;
    localparam logic [3:0] c_st_mem_wb   = 4'd5;
    localparam logic [3:0] c_st_mem_wr   = 4'd6;
    localparam logic [3:0] c_st_exec_r   = 4'd7;
    localparam logic [3:0] c_st_r_wb     = 4'd8;
    localparam logic [3:0] c_st_exec_i   = 4'd9;
    localparam logic [3:0] c_st_i_wb     = 4'd10;
    localparam logic [3:0] c_st_branch   = 4'd11;
    localparam logic [3:0] c_st_jump     = 4'd12;

    // Opcodes are compared after zero-extension so a narrow OP_W never
    // aliases onto a legal encoding.
    localparam logic [31:0] c_op_r    = 32'd0;
    localparam logic [31:0] c_op_j    = 32'd2;
    localparam logic [31:0] c_op_beq  = 32'd4;
    localparam logic [31:0] c_op_addi = 32'd8;
    localparam logic [31:0] c_op_slti = 32'd10;
    localparam logic [31:0] c_op_lw   = 32'd35;
    localparam logic [31:0] c_op_sw   = 32'd43;

    logic [3:0]      r_state;
    logic [OP_W-1:0] r_op;
    logic            r_illegal;
    logic [CNT_W-1:0] r_cnt;

    logic            w_ready;
    logic [31:0]     w_op_in;
    logic [31:0]     w_op_lat;
    logic [2:0]      w_alu3;

    assign w_ready  = (USE_READY != 0) ? mem_ready_i : 1'b1;
    assign w_op_in  = 32'(instr_op_i);
    assign w_op_lat = 32'(r_op);

    assign state_o       = r_state;
    assign illegal_o     = r_illegal;
    assign retired_cnt_o = r_cnt;
    assign alu_op_o      = ALUOP_W'(w_alu3);

    // Datapath control decode from the registered state. pc_write/ir_write
    // in FETCH and retire in MEM_WR follow the memory handshake.
    always_comb begin
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        pc_source_o     = 2'b00;
        i_or_d_o        = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        ir_write_o      = 1'b0;
        reg_dst_o       = 1'b0;
        mem_to_reg_o    = 1'b0;
        reg_write_o     = 1'b0;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = 2'b00;
        w_alu3          = 3'b000;
        retire_o        = 1'b0;
        case (r_state)
            c_st_fetch: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = 2'b01;
                pc_write_o  = w_ready;
                ir_write_o  = w_ready;
            end
            c_st_decode: begin
                // Speculative branch target into ALUOut.
                alu_src_b_o = 2'b11;
            end
            c_st_mem_addr: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
            end
            c_st_mem_rd: begin
                mem_read_o = 1'b1;
                i_or_d_o   = 1'b1;
            end
            c_st_mem_wb: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
                retire_o     = 1'b1;
            end
            c_st_mem_wr: begin
                mem_write_o = 1'b1;
                i_or_d_o    = 1'b1;
                retire_o    = w_ready;
            end
            c_st_exec_r: begin
                alu_src_a_o = 1'b1;
                w_alu3      = 3'b100;
            end
            c_st_r_wb: begin
                reg_write_o = 1'b1;
                reg_dst_o   = 1'b1;
                retire_o    = 1'b1;
            end
            c_st_exec_i: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                w_alu3      = (w_op_lat == c_op_slti) ? 3'b001 : 3'b010;
            end
            c_st_i_wb: begin
                reg_write_o = 1'b1;
                retire_o    = 1'b1;
            end
            c_st_branch: begin
                alu_src_a_o     = 1'b1;
                w_alu3          = 3'b011;
                pc_write_cond_o = 1'b1;
                pc_source_o     = 2'b01;
                retire_o        = 1'b1;
            end
            c_st_jump: begin
                pc_write_o  = 1'b1;
                pc_source_o = 2'b10;
                retire_o    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= c_st_idle;
            r_op      <= '0;
            r_illegal <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (retire_o) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            case (r_state)
                c_st_idle:  r_state <= c_st_fetch;
                c_st_fetch: if (w_ready) r_state <= c_st_decode;
                c_st_decode: begin
                    r_op <= instr_op_i;
                    case (w_op_in)
                        c_op_lw, c_op_sw:     r_state <= c_st_mem_addr;
                        c_op_r:               r_state <= c_st_exec_r;
                        c_op_addi, c_op_slti: r_state <= c_st_exec_i;
                        c_op_beq:             r_state <= c_st_branch;
                        c_op_j:               r_state <= c_st_jump;
                        default: begin
                            r_illegal <= 1'b1;
                            r_state   <= c_st_fetch;
                        end
                    endcase
                end
                c_st_mem_addr: r_state <= (w_op_lat == c_op_lw) ? c_st_mem_rd : c_st_mem_wr;
                c_st_mem_rd:   if (w_ready) r_state <= c_st_mem_wb;
                c_st_mem_wr:   if (w_ready) r_state <= c_st_fetch;
                c_st_exec_r:   r_state <= c_st_r_wb;
                c_st_exec_i:   r_state <= c_st_i_wb;
                c_st_mem_wb, c_st_r_wb, c_st_i_wb, c_st_branch, c_st_jump:
                               r_state <= c_st_fetch;
                default:       r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_ctrl_unit
// Purpose  : Self-checking bench for mc_ctrl_unit. Instruction-level model
//            expands each opcode into its expected per-cycle state sequence
//            (with wait states) and checks controls, retire, flag and count.
//            dut_a: default parameters; dut_b: CNT_W=2, USE_READY=0.
// Revision : 1.0  initial release
// ============================================================================
module tb_mc_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst_a_n, rst_b_n;
    logic [5:0] op;
    logic       ready;
    int         sel;

    always #5 clk = ~clk;

    logic        a_pcw, a_pcwc, a_iord, a_mr, a_mw, a_irw, a_rdst, a_m2r, a_rw, a_sa, a_ret, a_ill;
    logic [1:0]  a_ps, a_sb;
    logic [2:0]  a_alu;
    logic [15:0] a_cnt;
    logic [3:0]  a_st;
    logic        b_pcw, b_pcwc, b_iord, b_mr, b_mw, b_irw, b_rdst, b_m2r, b_rw, b_sa, b_ret, b_ill;
    logic [1:0]  b_ps, b_sb;
    logic [2:0]  b_alu;
    logic [1:0]  b_cnt;
    logic [3:0]  b_st;

    mc_ctrl_unit dut_a (
        .clk_i(clk), .rst_i(rst_a_n), .instr_op_i(op), .mem_ready_i(ready),
        .pc_write_o(a_pcw), .pc_write_cond_o(a_pcwc), .pc_source_o(a_ps),
        .i_or_d_o(a_iord), .mem_read_o(a_mr), .mem_write_o(a_mw),
        .ir_write_o(a_irw), .reg_dst_o(a_rdst), .mem_to_reg_o(a_m2r),
        .reg_write_o(a_rw), .alu_src_a_o(a_sa), .alu_src_b_o(a_sb),
        .alu_op_o(a_alu), .retire_o(a_ret), .illegal_o(a_ill),
        .retired_cnt_o(a_cnt), .state_o(a_st));

    mc_ctrl_unit #(.CNT_W(2), .USE_READY(0)) dut_b (
        .clk_i(clk), .rst_i(rst_b_n), .instr_op_i(op), .mem_ready_i(ready),
        .pc_write_o(b_pcw), .pc_write_cond_o(b_pcwc), .pc_source_o(b_ps),
        .i_or_d_o(b_iord), .mem_read_o(b_mr), .mem_write_o(b_mw),
        .ir_write_o(b_irw), .reg_dst_o(b_rdst), .mem_to_reg_o(b_m2r),
        .reg_write_o(b_rw), .alu_src_a_o(b_sa), .alu_src_b_o(b_sb),
        .alu_op_o(b_alu), .retire_o(b_ret), .illegal_o(b_ill),
        .retired_cnt_o(b_cnt), .state_o(b_st));

    // Observed view of whichever DUT is under test.
    logic [16:0] obs_ctrl;
    logic [31:0] obs_cnt;
    logic [3:0]  obs_st;
    logic        obs_ret, obs_ill;
    always_comb begin
        if (sel == 0) begin
            obs_ctrl = {a_pcw, a_pcwc, a_ps, a_iord, a_mr, a_mw, a_irw, a_rdst, a_m2r, a_rw, a_sa, a_sb, a_alu};
            obs_cnt  = 32'(a_cnt);
            obs_st   = a_st;
            obs_ret  = a_ret;
            obs_ill  = a_ill;
        end else begin
            obs_ctrl = {b_pcw, b_pcwc, b_ps, b_iord, b_mr, b_mw, b_irw, b_rdst, b_m2r, b_rw, b_sa, b_sb, b_alu};
            obs_cnt  = 32'(b_cnt);
            obs_st   = b_st;
            obs_ret  = b_ret;
            obs_ill  = b_ill;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Control word the spec's state table demands: order is
    // pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
    // ir_write, reg_dst, mem_to_reg, reg_write, src_a, src_b, alu_op.
    function automatic logic [16:0] exp_ctrl(logic [3:0] st, int iop, bit rdy);
        logic pcw, pcwc, iord, mr, mw, irw, rdst, m2r, rw, sa;
        logic [1:0] ps, sb;
        logic [2:0] alu;
        {pcw, pcwc, iord, mr, mw, irw, rdst, m2r, rw, sa} = '0;
        ps = 2'b00; sb = 2'b00; alu = 3'b000;
        case (st)
            4'd1:  begin mr = 1; sb = 2'b01; pcw = rdy; irw = rdy; end
            4'd2:  sb = 2'b11;
            4'd3:  begin sa = 1; sb = 2'b10; end
            4'd4:  begin mr = 1; iord = 1; end
            4'd5:  begin rw = 1; m2r = 1; end
            4'd6:  begin mw = 1; iord = 1; end
            4'd7:  begin sa = 1; alu = 3'b100; end
            4'd8:  begin rw = 1; rdst = 1; end
            4'd9:  begin sa = 1; sb = 2'b10; alu = (iop == 10) ? 3'b001 : 3'b010; end
            4'd10: rw = 1;
            4'd11: begin sa = 1; alu = 3'b011; pcwc = 1; ps = 2'b01; end
            4'd12: begin pcw = 1; ps = 2'b10; end
            default: ;
        endcase
        return {pcw, pcwc, ps, iord, mr, mw, irw, rdst, m2r, rw, sa, sb, alu};
    endfunction

    typedef struct {
        logic [3:0] st;
        bit         rdy;    // value driven on mem_ready_i
        bit         eff;    // ready as the DUT should see it
        bit         last;
        bit         legal;
        int         iop;
    } step_t;

    step_t q[$];
    int    m_cnt;
    int    m_mask;
    bit    m_ill;

    function automatic void push(logic [3:0] st, bit rdy, bit eff, bit last, bit legal, int iop);
        step_t s;
        s.st = st; s.rdy = rdy; s.eff = eff; s.last = last; s.legal = legal; s.iop = iop;
        q.push_back(s);
    endfunction

    function automatic bit rnd();
        return 1'($urandom);
    endfunction

    // Memory-access phase: mw stall cycles then the ready cycle, or one
    // cycle regardless of the ready input when ready is ignored.
    function automatic void push_mem(logic [3:0] st, int mw, bit nr, bit last_on_ready, int iop);
        if (nr) begin
            push(st, rnd(), 1'b1, last_on_ready, 1'b1, iop);
        end else begin
            for (int i = 0; i < mw; i++) push(st, 1'b0, 1'b0, 1'b0, 1'b1, iop);
            push(st, 1'b1, 1'b1, last_on_ready, 1'b1, iop);
        end
    endfunction

    // Expand one instruction into its expected cycle sequence.
    function automatic void build(int iop, int fw, int mw, bit idle, bit nr);
        bit legal;
        legal = (iop == 0 || iop == 2 || iop == 4 || iop == 8 || iop == 10 || iop == 35 || iop == 43);
        if (idle) push(4'd0, rnd(), 1'b0, 1'b0, 1'b1, iop);
        push_mem(4'd1, fw, nr, 1'b0, iop);
        push(4'd2, rnd(), 1'b0, !legal, legal, iop);
        case (iop)
            35: begin push(4'd3, rnd(), 0, 0, 1, iop); push_mem(4'd4, mw, nr, 1'b0, iop); push(4'd5, rnd(), 0, 1, 1, iop); end
            43: begin push(4'd3, rnd(), 0, 0, 1, iop); push_mem(4'd6, mw, nr, 1'b1, iop); end
            0:  begin push(4'd7, rnd(), 0, 0, 1, iop); push(4'd8, rnd(), 0, 1, 1, iop); end
            8, 10: begin push(4'd9, rnd(), 0, 0, 1, iop); push(4'd10, rnd(), 0, 1, 1, iop); end
            4:  push(4'd11, rnd(), 0, 1, 1, iop);
            2:  push(4'd12, rnd(), 0, 1, 1, iop);
            default: ;
        endcase
    endfunction

    // Apply up to n queued cycles (n<0: all), checking each one.
    task automatic run(int n);
        step_t s;
        int done = 0;
        while (q.size() > 0 && (n < 0 || done < n)) begin
            s = q.pop_front();
            @(negedge clk);
            ready = s.rdy;
            op    = (s.st == 4'd2) ? 6'(s.iop) : 6'($urandom);
            #1;
            check("state",   32'(obs_st),   32'(s.st));
            check("ctrl",    32'(obs_ctrl), 32'(exp_ctrl(s.st, s.iop, s.eff)));
            check("retire",  32'(obs_ret),  32'(s.last && s.legal));
            check("illegal", 32'(obs_ill),  32'(m_ill));
            check("count",   obs_cnt,       32'(m_cnt));
            if (s.last && s.legal) m_cnt = (m_cnt + 1) & m_mask;
            if (s.st == 4'd2 && !s.legal) m_ill = 1'b1;
            done++;
        end
    endtask

    task automatic check_reset_state(string tag);
        check({tag, "_state"}, 32'(obs_st), 32'd0);
        check({tag, "_ctrl"},  32'(obs_ctrl), 32'd0);
        check({tag, "_ret"},   32'(obs_ret), 32'd0);
        check({tag, "_ill"},   32'(obs_ill), 32'd0);
        check({tag, "_cnt"},   obs_cnt, 32'd0);
    endtask

    int legal_ops[7] = '{0, 2, 4, 8, 10, 35, 43};

    initial begin
        sel = 0; rst_a_n = 1'b0; rst_b_n = 1'b0; ready = 1'b0; op = '0;
        m_cnt = 0; m_ill = 1'b0; m_mask = 32'hFFFF;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check_reset_state("rst_a");

        // Directed program, then random instructions with random waits.
        build(0, 0, 0, 1'b1, 1'b0);
        build(35, 0, 3, 1'b0, 1'b0);
        build(4, 0, 0, 1'b0, 1'b0);
        build(2, 0, 0, 1'b0, 1'b0);
        build(43, 0, 0, 1'b0, 1'b0);
        build(10, 0, 0, 1'b0, 1'b0);
        build(63, 0, 0, 1'b0, 1'b0);
        build(8, 1, 0, 1'b0, 1'b0);
        build(43, 2, 3, 1'b0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            int pick;
            int iop;
            pick = int'($urandom_range(0, 8));
            iop  = (pick < 7) ? legal_ops[pick] : ((pick == 7) ? 63 : 1);
            build(iop, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0, 1'b0);
        end
        @(posedge clk); #2 rst_a_n = 1'b1;
        run(-1);

        // CNT_W=2, ready ignored.
        @(negedge clk);
        rst_a_n = 1'b0;
        sel = 1; m_cnt = 0; m_ill = 1'b0; m_mask = 3;
        #1;
        check_reset_state("rst_b");
        for (int k = 0; k < 5; k++) begin
            build(legal_ops[$urandom_range(0, 6)], 0, 0, k == 0, 1'b1);
        end
        @(posedge clk); #2 rst_b_n = 1'b1;
        run(-1);
        @(negedge clk); #1;
        check("wrap_cnt",   obs_cnt, 32'd1);
        check("wrap_state", 32'(obs_st), 32'd1);

        // lw aborted by reset while in MEM_RD.
        build(35, 0, 0, 1'b0, 1'b1);
        void'(q.pop_front());
        run(2);
        q.delete();
        @(negedge clk); #1;
        check("memrd_state", 32'(obs_st), 32'd4);
        check("memrd_ctrl",  32'(obs_ctrl), 32'(exp_ctrl(4'd4, 35, 1'b1)));
        rst_b_n = 1'b0;
        #1;
        check_reset_state("abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
